inst_fetch_stage: RTL and testbench

- PC generation and instruction-fetch stage of the MIPS core.
- Sits directly upstream of the decode/control stage and consumes its redirect outputs (pc_src, j_src).
- Issues reads to a synchronous instruction SRAM with 1-cycle read latency, holds a one-entry skid buffer for decode stalls, and presents a valid/pc/inst triple to decode.
- Implements the MIPS branch delay slot.

---
 rtl/inst_fetch_stage.sv | 100 ++++++++++
 tb/tb_inst_fetch_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_stage.sv
// MIPS PC generation and instruction-fetch stage: issues 1-cycle-latency SRAM
// reads, buffers one word across decode stalls, and honours the branch delay slot.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter int          SRAM_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_allowin,
  input  logic [1:0]  pc_src,
  input  logic        j_src,
  input  logic [31:0] jr_target,
  input  logic [15:0] br_imm,
  input  logic [25:0] j_index,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  if (SRAM_LAT != 1) begin : g_lat_check
    $error("inst_fetch_stage supports only SRAM_LAT == 1");
  end

  logic        req_pending;
  logic [31:0] req_pc;
  logic        buf_valid;
  logic [31:0] buf_inst;
  logic [31:0] seq_pc;

  logic        advance;
  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_addr;

  // Low two bits of the register target are dropped to keep fetches word aligned.
  logic unused_jr_bits;
  assign unused_jr_bits = ^jr_target[1:0];

  assign advance   = ~if_valid | id_allowin;
  assign redirect  = if_valid & id_allowin & (pc_src != 2'b00);
  assign pc_plus4  = if_pc + 32'd4;
  assign br_target = pc_plus4 + {{14{br_imm[15]}}, br_imm, 2'b00};
  assign j_target  = {pc_plus4[31:28], j_index, 2'b00};

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    redirect_pc = br_target;
    if (pc_src[0]) begin
      redirect_pc = j_src ? {jr_target[31:2], 2'b00} : j_target;
    end
  end

  assign fetch_addr     = redirect ? redirect_pc : seq_pc;
  assign inst_sram_en   = resetn & advance;
  assign inst_sram_addr = fetch_addr;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_valid    <= 1'b0;
      if_pc       <= RESET_PC;
      if_inst     <= 32'd0;
      req_pending <= 1'b0;
      req_pc      <= RESET_PC;
      buf_valid   <= 1'b0;
      buf_inst    <= 32'd0;
      seq_pc      <= RESET_PC;
    end else if (advance) begin
      req_pending <= 1'b1;
      req_pc      <= fetch_addr;
      seq_pc      <= fetch_addr + 32'd4;
      if (buf_valid) begin
        if_inst   <= buf_inst;
        if_pc     <= req_pc;
        if_valid  <= 1'b1;
        buf_valid <= 1'b0;
      end else if (req_pending) begin
        if_inst  <= inst_sram_rdata;
        if_pc    <= req_pc;
        if_valid <= 1'b1;
      end else begin
        if_valid <= 1'b0;
      end
    end else begin
      // Stalled: the in-flight word is parked in the skid buffer, so nothing stays pending.
      req_pending <= 1'b0;
      if (req_pending && !buf_valid) begin
        buf_inst  <= inst_sram_rdata;
        buf_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: directed redirects/stalls, then random traffic,
// checked by a scoreboard fed from an architectural PC-stream model.
module tb_inst_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;

  logic        clk;
  logic        resetn;
  logic        id_allowin;
  logic [1:0]  pc_src;
  logic        j_src;
  logic [31:0] jr_target;
  logic [15:0] br_imm;
  logic [25:0] j_index;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  inst_fetch_stage #(.RESET_PC(RESET_PC), .SRAM_LAT(1)) dut (
    .clk(clk), .resetn(resetn), .id_allowin(id_allowin), .pc_src(pc_src),
    .j_src(j_src), .jr_target(jr_target), .br_imm(br_imm), .j_index(j_index),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata), .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory whose content at every address is the address itself.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_sram_addr;
  end

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_cur;
  logic [31:0] m_nxt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural next PC after a control-transfer instruction at pc.
  function automatic logic [31:0] target_of(input logic [31:0] pc, input logic [1:0] src,
                                            input logic js, input logic [31:0] jr,
                                            input logic [15:0] imm, input logic [25:0] idx);
    logic [31:0] seq;
    int off;
    seq = pc + 32'd4;
    if (src[0]) begin
      if (js) return jr & 32'hFFFF_FFFC;
      return (seq & 32'hF000_0000) | (32'(idx) * 4);
    end
    off = int'($signed(imm));
    return seq + 32'(off * 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of decode-side inputs; an accepted instruction pushes its expectation.
  task automatic apply(input logic allow, input logic [1:0] src, input logic js,
                       input logic [31:0] jr, input logic [15:0] imm, input logic [25:0] idx);
    logic [31:0] nt;
    id_allowin = allow;
    pc_src     = src;
    j_src      = js;
    jr_target  = jr;
    br_imm     = imm;
    j_index    = idx;
    if (resetn && if_valid && allow) begin
      exp_q.push_back(m_cur);
      nt    = (src != 2'b00) ? target_of(m_cur, src, js, jr, imm, idx) : m_nxt + 32'd4;
      m_cur = m_nxt;
      m_nxt = nt;
      n_acc++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, RESET_PC);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_sram_en", 32'(inst_sram_en), 32'd0);
    exp_q.delete();
    m_cur = RESET_PC;
    m_nxt = RESET_PC + 32'd4;
    id_allowin = 1'b1;
    pc_src     = 2'b00;
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
    #1;
    check("first_req_en", 32'(inst_sram_en), 32'd1);
    check("first_req_addr", inst_sram_addr, RESET_PC);
    tick();
    check("cycle1_if_valid", 32'(if_valid), 32'd0);
    check("cycle1_addr", inst_sram_addr, RESET_PC + 32'd4);
    apply(1'b1, 2'b00, 1'b0, 32'd0, 16'd0, 26'd0);
    tick();
    check("cycle2_if_valid", 32'(if_valid), 32'd1);
    check("cycle2_if_pc", if_pc, RESET_PC);
    apply(1'b1, 2'b00, 1'b0, 32'd0, 16'd0, 26'd0);
  endtask

  // Monitor: compares every accepted instruction and checks stall behaviour.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;
    logic [31:0] e;
    prev_stall = 1'b0;
    prev_pc    = 32'd0;
    prev_inst  = 32'd0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold_valid", 32'(if_valid), 32'd1);
          check("stall_hold_pc", if_pc, prev_pc);
          check("stall_hold_inst", if_inst, prev_inst);
        end
        if (if_valid && !id_allowin) begin
          check("stall_sram_en", 32'(inst_sram_en), 32'd0);
        end
        if (if_valid && id_allowin) begin
          if (exp_q.size() == 0) begin
            check("unexpected_accept_pc", if_pc, 32'hxxxx_xxxx);
          end else begin
            e = exp_q.pop_front();
            check("accept_pc", if_pc, e);
            check("accept_inst", if_inst, e);
          end
        end
        prev_stall = if_valid && !id_allowin;
        prev_pc    = if_pc;
        prev_inst  = if_inst;
      end
    end
  end

  initial begin
    int stall_left;
    bit d_st, d_br, d_j, d_r1, d_jr;
    int acc_start;
    logic        allow;
    logic [1:0]  src;
    logic        js;
    logic [31:0] jr;
    logic [15:0] imm;
    logic [25:0] idx;
    int sel;

    resetn     = 1'b0;
    id_allowin = 1'b0;
    pc_src     = 2'b00;
    j_src      = 1'b0;
    jr_target  = 32'd0;
    br_imm     = 16'd0;
    j_index    = 26'd0;
    m_cur      = RESET_PC;
    m_nxt      = RESET_PC + 32'd4;

    do_reset();

    // Directed: stall at 08, branch at 10, j at 20, jr back into the stream, jr at 30.
    stall_left = 0;
    d_st = 0; d_br = 0; d_j = 0; d_r1 = 0; d_jr = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      allow = 1'b1; src = 2'b00; js = 1'b0; jr = 32'd0; imm = 16'd0; idx = 26'd0;
      if (stall_left > 0) begin
        allow = 1'b0;
        stall_left--;
      end else if (if_valid) begin
        if (m_cur == 32'hBFC00008 && !d_st) begin
          d_st = 1; allow = 1'b0; stall_left = 2;
        end else if (m_cur == 32'hBFC00010 && !d_br) begin
          d_br = 1; src = 2'b10; imm = 16'hFFFC;
        end else if (m_cur == 32'hBFC00020 && !d_j) begin
          d_j = 1; src = 2'b01; idx = 26'h0000100;
        end else if (m_cur == 32'hB0000400 && !d_r1) begin
          d_r1 = 1; src = 2'b01; js = 1'b1; jr = 32'hBFC0002C;
        end else if (m_cur == 32'hBFC00030 && !d_jr) begin
          d_jr = 1; src = 2'b01; js = 1'b1; jr = 32'h80001003;
        end
      end
      apply(allow, src, js, jr, imm, idx);
    end
    check("directed_jr_done", 32'(d_jr), 32'd1);
    check("directed_accepts", 32'(n_acc >= 25), 32'd1);

    // Random traffic, with one reset pulse landing in the middle of a stall.
    acc_start = n_acc;
    for (int i = 0; i < 700; i++) begin
      if (i == 350) begin
        tick();
        apply(1'b0, 2'b00, 1'b0, 32'd0, 16'd0, 26'd0);
        tick();
        apply(1'b0, 2'b00, 1'b0, 32'd0, 16'd0, 26'd0);
        do_reset();
      end
      tick();
      allow = ($urandom_range(0, 3) != 0);
      sel   = $urandom_range(0, 9);
      js    = 1'($urandom_range(0, 1));
      jr    = $urandom;
      imm   = 16'($urandom);
      idx   = 26'($urandom);
      case (sel)
        0, 1:    src = 2'b10;
        2, 3:    src = 2'b01;
        4:       src = 2'b11;
        default: src = 2'b00;
      endcase
      apply(allow, src, js, jr, imm, idx);
    end
    tick();
    apply(1'b0, 2'b00, 1'b0, 32'd0, 16'd0, 26'd0);
    @(negedge clk);
    #1;
    check("random_accepts", 32'(n_acc - acc_start >= 300), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
